// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier holding the HI/LO architectural registers.
// One Booth digit is retired per CALC cycle; the product lands in hi/lo on entry to DONE.
module booth_seq_mult #(
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     is_signed,
  input  logic [IN_DATA_WIDTH-1:0] a,
  input  logic [IN_DATA_WIDTH-1:0] b,
  input  logic                     flush,
  input  logic                     hi_we,
  input  logic                     lo_we,
  input  logic [IN_DATA_WIDTH-1:0] wdata,
  output logic                     busy,
  output logic                     done,
  output logic [IN_DATA_WIDTH-1:0] hi,
  output logic [IN_DATA_WIDTH-1:0] lo
);

  localparam int EW    = IN_DATA_WIDTH + 2;  // extended operand width
  localparam int AW    = EW + 2;             // upper accumulator, room for +/-2B
  localparam int STEPS = EW / 2;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  // Multiplier with the implicit zero below bit 0; the low product bits shift in at the top.
  logic [EW:0]   mq;
  logic [EW-1:0] mcand;

  logic [2:0]    digit;
  logic [AW-1:0] pp_mag;
  logic          pp_neg;
  logic [AW-1:0] sum;
  logic [AW-1:0] acc_next;
  logic [EW:0]   mq_next;

  assign digit = mq[2:0];

  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    case (digit)
      3'b001, 3'b010: pp_mag = {{2{mcand[EW-1]}}, mcand};
      3'b011:         pp_mag = {mcand[EW-1], mcand, 1'b0};
      3'b100: begin
        pp_mag = {mcand[EW-1], mcand, 1'b0};
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = {{2{mcand[EW-1]}}, mcand};
        pp_neg = 1'b1;
      end
      default: begin
        pp_mag = '0;
        pp_neg = 1'b0;
      end
    endcase
  end

  // Negative digits use the inverted magnitude plus a carry-in of one.
  assign sum      = acc + (pp_neg ? ~pp_mag : pp_mag) + AW'(pp_neg);
  assign acc_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign mq_next  = {sum[1:0], mq[EW:2]};

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            state <= CALC;
            cnt   <= '0;
            acc   <= '0;
            mq    <= {{2{is_signed & a[IN_DATA_WIDTH-1]}}, a, 1'b0};
            mcand <= {{2{is_signed & b[IN_DATA_WIDTH-1]}}, b};
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            mq  <= mq_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(STEPS - 1)) begin
              state <= DONE;
              hi    <= {acc_next[OUT_DATA_WIDTH-EW-1:0], mq_next[EW:IN_DATA_WIDTH+1]};
              lo    <= mq_next[IN_DATA_WIDTH:1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: expected products are queued at issue
// and popped when done pulses.
module tb_booth_seq_mult;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, is_signed, flush, hi_we, lo_we;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0]  exp_q[$];
  logic [W-1:0] exp_hi, exp_lo;

  booth_seq_mult #(.IN_DATA_WIDTH(W), .OUT_DATA_WIDTH(2*W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(bit s, logic [31:0] x, logic [31:0] y);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  task automatic issue(bit s, logic [31:0] x, logic [31:0] y);
    is_signed = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (hi !== '0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== '0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_products;
    bit          sv [14];
    logic [31:0] av [14];
    logic [31:0] bv [14];
    logic [63:0] e;
    int          lat;
    sv[0] = 0; av[0] = 32'hFFFFFFFF; bv[0] = 32'hFFFFFFFF;
    sv[1] = 1; av[1] = 32'hFFFFFFFF; bv[1] = 32'h00000002;
    sv[2] = 1; av[2] = 32'h80000000; bv[2] = 32'h80000000;
    sv[3] = 1; av[3] = 32'h00000007; bv[3] = 32'h00000006;
    sv[4] = 0; av[4] = 32'h80000000; bv[4] = 32'hFFFFFFFF;
    sv[5] = 1; av[5] = 32'h7FFFFFFF; bv[5] = 32'h80000000;
    sv[6] = 0; av[6] = 32'h00000000; bv[6] = 32'h12345678;
    sv[7] = 1; av[7] = 32'h12345678; bv[7] = 32'hFEDCBA98;
    for (int i = 8; i < 14; i++) begin
      sv[i] = 1'($urandom); av[i] = $urandom; bv[i] = $urandom;
    end
    for (int i = 0; i < 14; i++) begin
      issue(sv[i], av[i], bv[i]);
      exp_q.push_back(model(sv[i], av[i], bv[i]));
      wait_done(lat);
      n_checks++; if (lat != 17) begin n_fail++; $display("FAIL prod_latency[%0d]: got %0d want 17", i, lat); end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL prod_queue[%0d]: got empty want entry", i);
      end else begin
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin n_fail++; $display("FAIL prod[%0d]: got %h_%h want %h", i, hi, lo, e); end
        exp_hi = e[63:32]; exp_lo = e[31:0];
      end
      $display("op %0d signed=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", i, sv[i], av[i], bv[i], hi, lo, lat);
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse[%0d]: got %b want 0", i, done); end
    end
    // Fixed vectors from the product table, checked against literal constants.
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat);
    n_checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi, lo); end
    issue(1, 32'h80000000, 32'h80000000);
    wait_done(lat);
    n_checks++; if ({hi, lo} !== 64'h40000000_00000000) begin n_fail++; $display("FAIL mult_min: got %h_%h want 40000000_00000000", hi, lo); end
    exp_hi = 32'h40000000; exp_lo = 32'h0;
    $display("fixed vectors hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_flush;
    int dones;
    issue(1, 32'd7, 32'd6);
    repeat (4) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b want 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b want 0", busy); end
    dones = 0;
    repeat (25) begin @(posedge clk); #1; if (done) dones++; end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d want 0", dones); end
    n_checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL flush_hilo: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
    // flush together with start: nothing starts
    is_signed = 1'b1; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", busy); end
    $display("flush: busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_mthi;
    logic [63:0] e;
    int          lat;
    wdata = 32'h12345678; hi_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0;
    exp_hi = 32'h12345678;
    n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL mthi_idle: got %h want %h", hi, exp_hi); end
    issue(0, 32'd3, 32'd5);
    exp_q.push_back(model(0, 32'd3, 32'd5));
    repeat (2) begin @(posedge clk); #1; end
    wdata = 32'hDEADBEEF; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    n_checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL mthi_calc_drop: got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); end
    wait_done(lat);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL mthi_queue: got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL mthi_product: got %h_%h want %h", hi, lo, e); end
    end
    // MTLO accepted in the same cycle as start, later overwritten by the product
    wdata = 32'hCAFEF00D; lo_we = 1'b1;
    is_signed = 1'b1; a = 32'hFFFFFFFD; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    exp_q.push_back(model(1, 32'hFFFFFFFD, 32'd9));
    n_checks++; if (lo !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mtlo_with_start: got %h want cafef00d", lo); end
    wait_done(lat);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL mtlo_queue: got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL mtlo_product: got %h_%h want %h", hi, lo, e); end
      exp_hi = e[63:32]; exp_lo = e[31:0];
    end
    $display("mthi/mtlo: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    int          lat;
    issue(1, 32'hFFFF0001, 32'h0000FFFF);
    exp_q.push_back(model(1, 32'hFFFF0001, 32'h0000FFFF));
    wait_done(lat);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL b2b_queue0: got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL b2b_product0: got %h_%h want %h", hi, lo, e); end
    end
    issue(0, 32'hABCDEF01, 32'h10203040);
    exp_q.push_back(model(0, 32'hABCDEF01, 32'h10203040));
    wait_done(lat);
    n_checks++; if (lat + 1 != 18) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 18", lat + 1); end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL b2b_queue1: got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL b2b_product1: got %h_%h want %h", hi, lo, e); end
      exp_hi = e[63:32]; exp_lo = e[31:0];
    end
    $display("back_to_back: spacing=%0d hi=%h lo=%h", lat + 1, hi, lo);
  endtask

  task automatic test_start_ignored;
    logic [63:0] e;
    int          lat;
    issue(0, 32'd100, 32'd200);
    exp_q.push_back(model(0, 32'd100, 32'd200));
    repeat (3) begin @(posedge clk); #1; end
    is_signed = 1'b1; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    n_checks++; if (lat != 13) begin n_fail++; $display("FAIL ignored_latency: got %0d want 13", lat); end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL ignored_queue: got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL ignored_product: got %h_%h want %h", hi, lo, e); end
      exp_hi = e[63:32]; exp_lo = e[31:0];
    end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_no_queue: got %b want 0", busy); end
    $display("start_in_calc: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_rst_mid;
    logic [63:0] e;
    int          lat, dones;
    issue(1, 32'h00001234, 32'hFFFFFF00);
    repeat (6) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL rstmid_hilo: got %h_%h want 0", hi, lo); end
    #1 rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    dones = 0;
    repeat (25) begin @(posedge clk); #1; if (done) dones++; end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
    issue(1, 32'h00001234, 32'hFFFFFF00);
    exp_q.push_back(model(1, 32'h00001234, 32'hFFFFFF00));
    wait_done(lat);
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 17", lat); end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL rstmid_queue: got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if ({hi, lo} !== e) begin n_fail++; $display("FAIL rstmid_product: got %h_%h want %h", hi, lo, e); end
    end
    $display("rst_mid_calc: restart hi=%h lo=%h lat=%0d", hi, lo, lat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; a = '0; b = '0; wdata = '0;
    exp_hi = '0; exp_lo = '0;
    test_reset;
    test_products;
    test_flush;
    test_mthi;
    test_back_to_back;
    test_start_ignored;
    test_rst_mid;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drained: got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
